// File: rtl/usb_bit_stuffer.sv
// USB low/full-speed transmit bit stuffer.
// Sits between the packet serializer and the NRZI encoder. After every run of
// RUN_LEN consecutive 1s it inserts a 0 so the NRZI line always toggles. The
// end-of-packet flag rides on the trailing stuffed 0 when the packet ends in
// a full run, so the EOP generator only fires once stuffing is complete.
module usb_bit_stuffer #(
  parameter int RUN_LEN = 6,
  localparam int CNT_W = $clog2(RUN_LEN + 1)
) (
  input  logic clk,
  input  logic nRST,
  input  logic in_bit,
  input  logic in_valid,
  input  logic in_last,
  output logic in_ready,
  output logic out_bit,
  output logic out_valid,
  output logic out_last,
  input  logic out_ready,
  output logic stuff_event,
  output logic busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_STUFF  = 2'd2
  } state_t;

  // Count value at which one more 1 completes a run and forces a stuffed 0.
  localparam logic [CNT_W-1:0] RUN_MAX = CNT_W'(RUN_LEN - 1);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] run_cnt_reg, run_cnt_next;
  logic             pending_last_reg, pending_last_next;
  logic             out_bit_reg, out_bit_next;
  logic             out_valid_reg, out_valid_next;
  logic             out_last_reg, out_last_next;

  logic slot_free;
  logic stuff_now;

  // The single output slot can be reloaded when empty or being drained now.
  assign slot_free = !out_valid_reg || out_ready;
  // The owed stuffed 0 goes out whenever the slot is available.
  assign stuff_now = slot_free && (state_reg == ST_STUFF);

  assign in_ready    = slot_free && (state_reg != ST_STUFF);
  assign stuff_event = stuff_now;
  assign busy        = (state_reg != ST_IDLE) || out_valid_reg;
  assign out_bit     = out_bit_reg;
  assign out_valid   = out_valid_reg;
  assign out_last    = out_last_reg;

  // State and output register; reset drops anything in flight.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_reg        <= ST_IDLE;
      run_cnt_reg      <= '0;
      pending_last_reg <= 1'b0;
      out_bit_reg      <= 1'b0;
      out_valid_reg    <= 1'b0;
      out_last_reg     <= 1'b0;
    end else begin
      state_reg        <= state_next;
      run_cnt_reg      <= run_cnt_next;
      pending_last_reg <= pending_last_next;
      out_bit_reg      <= out_bit_next;
      out_valid_reg    <= out_valid_next;
      out_last_reg     <= out_last_next;
    end
  end

  // Load selection: stuffed 0 first, then new input, otherwise drain the slot.
  always_comb begin
    state_next        = state_reg;
    run_cnt_next      = run_cnt_reg;
    pending_last_next = pending_last_reg;
    out_bit_next      = out_bit_reg;
    out_valid_next    = out_valid_reg;
    out_last_next     = out_last_reg;

    if (slot_free) begin
      if (state_reg == ST_STUFF) begin
        // Emit the stuffed 0; it inherits the packet end if the run closed it.
        out_bit_next   = 1'b0;
        out_valid_next = 1'b1;
        out_last_next  = pending_last_reg;
        run_cnt_next   = '0;
        state_next     = pending_last_reg ? ST_IDLE : ST_ACTIVE;
      end else if (in_valid) begin
        out_bit_next   = in_bit;
        out_valid_next = 1'b1;
        run_cnt_next   = in_bit ? (run_cnt_reg + 1'b1) : '0;
        if (in_bit && (run_cnt_reg == RUN_MAX)) begin
          // Run complete: hold the last flag until the stuffed 0 leaves.
          out_last_next     = 1'b0;
          pending_last_next = in_last;
          state_next        = ST_STUFF;
        end else begin
          out_last_next = in_last;
          if (in_last) begin
            // Runs never carry across packet boundaries.
            run_cnt_next = '0;
            state_next   = ST_IDLE;
          end else begin
            state_next = ST_ACTIVE;
          end
        end
      end else begin
        out_valid_next = 1'b0;
      end
    end
  end

endmodule

// File: doc/usb_bit_stuffer.md
Name: usb_bit_stuffer

Overview:
Transmit-side bit stuffer for the USB low/full-speed serial path, placed between the packet serializer and the NRZI encoder. It accepts a raw packet bitstream over a valid/ready handshake. After every run of RUN_LEN consecutive 1s it inserts one 0, so the NRZI line is guaranteed a transition. It carries the end-of-packet marker past any trailing stuffed bit, so the EOP generator fires only after stuffing completes.

Parameters:
RUN_LEN, 6, number of consecutive 1s that forces a stuffed 0 (legal range >= 2; USB requires 6)
CNT_W, $clog2(RUN_LEN+1), width of the internal run counter (derived, not overridden)

Ports:
clk  input  1  system clock, all logic on rising edge
nRST  input  1  asynchronous active-low reset
in_bit  input  1  raw (unstuffed) data bit
in_valid  input  1  in_bit/in_last valid
in_last  input  1  in_bit is final bit of packet
in_ready  output  1  stuffer accepts input this cycle (combinational)
out_bit  output  1  stuffed bitstream bit
out_valid  output  1  out_bit/out_last valid (registered)
out_last  output  1  out_bit is final bit of stuffed packet
out_ready  input  1  downstream consumes out_bit this cycle
stuff_event  output  1  one-cycle pulse: a stuffed 0 was loaded into the output register
busy  output  1  packet in progress or output register occupied

Behaviour:
- Reset (async, nRST=0):
  - out_bit, out_valid, out_last, stuff_event = 0
  - run count = 0, stuff_pending = 0, state = IDLE
  - Reset mid-packet discards everything in flight; no partial flush.
- Output register: single entry.
  - slot_free = !out_valid || out_ready
  - A transfer occurs when out_valid && out_ready.
  - out_* must hold stable while out_valid && !out_ready.
- in_ready = slot_free && (state != STUFF).
- Latency: a bit accepted in cycle N appears on out_* in cycle N+1.
- Throughput: 1 bit/cycle with out_ready held high, minus one input bubble per stuffed bit.
- Load priority when slot_free, evaluated each cycle:
  1. state == STUFF: load out_bit=0, out_last=pending_last, out_valid=1; pulse stuff_event; run count=0. Next state = IDLE if pending_last, else ACTIVE.
  2. else if in_valid (accept): load out_bit=in_bit, out_valid=1.
     - in_bit=1: run count+1. in_bit=0: run count=0.
     - Trigger = in_bit=1 && run count==RUN_LEN-1. On trigger: out_last=0, pending_last=in_last, state=STUFF.
     - No trigger: out_last=in_last. If in_last: run count=0, state=IDLE; else state=ACTIVE.
  3. else if out_ready: out_valid=0.
- States:
  - IDLE: between packets, run count = 0.
  - ACTIVE: mid-packet.
  - STUFF: stuffed 0 owed; input blocked.
- Run count never exceeds RUN_LEN-1 outside STUFF. It is always cleared by a stuffed 0, a data 0, or packet end, so runs never carry across packets.
- Single-bit packet (in_last on first bit): IDLE stays IDLE, unless RUN_LEN==1 (illegal).
- Trigger on the last bit: the trailing stuffed 0 is emitted and out_last moves to it. out_last is never asserted on the triggering 1.
- stuff_event is 0 in every cycle that does not execute rule 1.
- busy = (state != IDLE) || out_valid.
- in_valid with in_ready=0 must be held by upstream; no input is dropped or duplicated.

Test Plan:
1. Send 1,1,1,1,1,1,1,0 (in_last on final 0), out_ready=1 → out stream 1,1,1,1,1,1,0,1,0. out_last only on the final 0. stuff_event pulses once, in the cycle after the 6th 1 is accepted. in_ready low exactly that cycle.
2. Six 1s with in_last on the 6th → seven output bits 1×6 then 0. out_last=1 only on the stuffed 0. busy drops the cycle after it transfers.
3. Twelve consecutive 1s, last on the 12th → 1×6,0,1×6,0 (14 bits). stuff_event pulses twice. out_last on the 14th bit.
4. Six 1s with out_ready forced low for 3 cycles once state=STUFF → out_bit=1/out_valid=1 held stable, in_ready=0 throughout. After release, the stuffed 0 is transferred next. Total output count is unchanged.
5. Packet A: five 1s, last on the 5th. Packet B: 1,1,0, last on the 0 → no stuffing in either packet (counter cleared at packet end). Also 1×5,0,1×5 → no stuffing.
6. Assert nRST while state=STUFF → all outputs 0 immediately (async). Then a fresh packet of six 1s stuffs after the 6th bit of the new packet, not earlier.
